hazard3_bus_arbiter: RTL

//  Shares one AHB-Lite master port between instruction fetch (I) and load/store (D).

---
 rtl/hazard3_bus_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/hazard3_bus_arbiter.sv
// hazard3_bus_arbiter
// Shares one AHB-Lite master port between instruction fetch (I) and
// load/store (D). Load/store has fixed priority over fetch, but a fetch that
// keeps losing is forced through once the starvation counter saturates.
// The arbiter also tracks which requester owns the current data phase and
// steers hready/hresp back to that requester only.
module hazard3_bus_arbiter #(
  parameter int W_ADDR       = 32,
  parameter int W_DATA       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_req,
  input  logic [W_ADDR-1:0] i_addr,
  input  logic [2:0]        i_size,
  output logic              i_gnt,
  output logic              i_rdy,
  output logic              i_err,
  output logic [W_DATA-1:0] i_rdata,

  input  logic              d_req,
  input  logic [W_ADDR-1:0] d_addr,
  input  logic [2:0]        d_size,
  input  logic              d_write,
  input  logic [W_DATA-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rdy,
  output logic              d_err,
  output logic [W_DATA-1:0] d_rdata,

  output logic [W_ADDR-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  input  logic              hready,
  input  logic              hresp,
  output logic [W_DATA-1:0] hwdata,
  input  logic [W_DATA-1:0] hrdata
);

  localparam int            CW        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT     = CW'(STARVE_LIMIT);
  localparam bit            STARVE_EN = (STARVE_LIMIT != 0);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Saturating increment; with the counter disabled LIMIT is 0 and the
  // counter simply stays at 0.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v >= LIMIT) return LIMIT;
    return v + CW'(1);
  endfunction

  logic [1:0]    owner_q, owner_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          force_i;
  logic          win_i;
  logic          win_d;
  logic          err_first;
  logic          addr_ok;

  // Arbitration: D wins unless I has lost STARVE_LIMIT times in a row.
  assign force_i   = STARVE_EN && (starve_q == LIMIT);
  assign win_i     = i_req && (!d_req || force_i);
  assign win_d     = d_req && !win_i;

  // First cycle of a two-cycle ERROR response must present IDLE; while in
  // reset no address phase may be offered either.
  assign err_first = hresp && !hready;
  assign addr_ok   = rst_n && !err_first;

  assign htrans = (addr_ok && (win_i || win_d)) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr  = win_d ? d_addr : i_addr;
  assign hsize  = win_d ? d_size : i_size;
  assign hwrite = win_d && d_write;

  assign i_gnt  = hready && addr_ok && win_i;
  assign d_gnt  = hready && addr_ok && win_d;

  // Data-phase response steering; read data is broadcast unqualified.
  assign i_rdy   = hready && (owner_q == OWN_I);
  assign d_rdy   = hready && (owner_q == OWN_D);
  assign i_err   = i_rdy && hresp;
  assign d_err   = d_rdy && hresp;
  assign i_rdata = hrdata;
  assign d_rdata = hrdata;
  assign hwdata  = d_wdata;

  // Next data-phase owner: whoever was granted on an hready cycle, else hold.
  always_comb begin
    owner_d = owner_q;
    if (hready) begin
      if (i_gnt)      owner_d = OWN_I;
      else if (d_gnt) owner_d = OWN_D;
      else            owner_d = OWN_NONE;
    end
  end

  // Next starvation count: cleared when I wins, bumped when I loses to D.
  always_comb begin
    starve_d = starve_q;
    if (hready) begin
      if (i_gnt)                starve_d = '0;
      else if (i_req && d_gnt)  starve_d = sat_inc(starve_q);
    end
  end

  // State registers; reset drops any in-flight data phase ownership.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

endmodule
